// File: rtl/div_iter_pkg.sv
// Shared widths, state encoding and magnitude helper for the iterative divider.
package div_iter_pkg;

    localparam int unsigned DWORD_W         = 32;
    localparam int unsigned DATA_W          = 64;
    localparam int unsigned CNT_W           = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 32;

    localparam logic [DWORD_W-1:0] ZERO_DWORD = '0;
    localparam logic [DWORD_W-1:0] ONES_DWORD = '1;
    localparam logic [DATA_W-1:0]  ZERO_DATA  = '0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Absolute value when the operand is treated as signed, passthrough otherwise.
    function automatic logic [DWORD_W-1:0] mag(input logic [DWORD_W-1:0] v,
                                               input logic              is_signed);
        return (is_signed && v[DWORD_W-1]) ? DWORD_W'(-v) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the EX stage.
// Optional: define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sign,
    input  logic [DWORD_W-1:0]  opa,
    input  logic [DWORD_W-1:0]  opb,
    input  logic                take,
    input  logic                flush,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   result
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DWORD_W-1:0]  rem_q, rem_d;
    logic [DWORD_W-1:0]  quo_q, quo_d;
    logic [DWORD_W-1:0]  dvs_q, dvs_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   result_q, result_d;

    logic                accept;
    logic [DWORD_W-1:0]  a_mag, b_mag;
    logic [DWORD_W:0]    shifted;
    logic                no_borrow;
    logic [DWORD_W-1:0]  rem_nx, quo_nx;

    // Next-state, datapath step and busy decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        accept = start && !flush &&
                 ((state_q == DIV_IDLE) || ((state_q == DIV_DONE) && take));
        busy   = (state_q == DIV_CALC) || accept;

        a_mag = mag(opa, sign);
        b_mag = mag(opb, sign);

        // Shifted partial remainder can reach 33 bits when the divisor exceeds 2^31.
        shifted   = {rem_q, quo_q[DWORD_W-1]};
        no_borrow = (shifted >= {1'b0, dvs_q});
        rem_nx    = no_borrow ? DWORD_W'(shifted - {1'b0, dvs_q}) : shifted[DWORD_W-1:0];
        quo_nx    = {quo_q[DWORD_W-2:0], no_borrow};

        case (state_q)
            DIV_IDLE: ;
            DIV_CALC: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = CNT_W'(cnt_q + 1'b1);
                if (cnt_q == LAST_CNT) begin
                    result_d = {(neg_rem_q ? DWORD_W'(-rem_nx) : rem_nx),
                                (neg_quo_q ? DWORD_W'(-quo_nx) : quo_nx)};
                    state_d  = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (take && !start) state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase

        if (accept) begin
            neg_quo_d = sign & (opa[DWORD_W-1] ^ opb[DWORD_W-1]);
            neg_rem_d = sign & opa[DWORD_W-1];
            rem_d     = ZERO_DWORD;
            quo_d     = a_mag;
            dvs_d     = b_mag;
            cnt_d     = '0;
            if (opb == ZERO_DWORD) begin
                state_d  = DIV_DONE;
                result_d = {opa, ONES_DWORD};
            end else begin
`ifdef DIV_EARLY_OUT_EN
                if (a_mag < b_mag) begin
                    state_d  = DIV_DONE;
                    result_d = {opa, ZERO_DWORD};
                end else begin
                    state_d  = DIV_CALC;
                end
`else
                state_d = DIV_CALC;
`endif
            end
        end

        if (flush) state_d = DIV_IDLE;

        done_d = (state_d == DIV_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= ZERO_DWORD;
            quo_q     <= ZERO_DWORD;
            dvs_q     <= ZERO_DWORD;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= ZERO_DATA;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter.
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sign;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        take;
    logic        flush;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int n_cmp = 0;
    int n_err = 0;
    int early_lat;

    div_iter #(.DIV_CYCLES(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sign   (sign),
        .opa    (opa),
        .opb    (opb),
        .take   (take),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 2ns after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Issue one divide at the current cycle (cycle 0) and check it through to done.
    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [63:0] exp);
        start = 1'b1;
        sign  = s;
        opa   = a;
        opb   = b;
        #1;
        chk({tag, " busy@start"}, 64'(busy), 64'(1));
        step();
        start = 1'b0;
        take  = 1'b0;
        opa   = 32'h0;
        opb   = 32'h0;
        for (int c = 1; c < lat; c++) begin
            chk($sformatf("%s busy@%0d", tag, c), 64'(busy), 64'(1));
            chk($sformatf("%s done@%0d", tag, c), 64'(done), 64'(0));
            step();
        end
        chk({tag, " done"}, 64'(done), 64'(1));
        chk({tag, " busy_low"}, 64'(busy), 64'(0));
        chk({tag, " result"}, result, exp);
    endtask

    initial begin
`ifdef DIV_EARLY_OUT_EN
        early_lat = 1;
`else
        early_lat = 33;
`endif
        rst   = 1'b1;
        start = 1'b0;
        sign  = 1'b0;
        opa   = 32'h0;
        opb   = 32'h0;
        take  = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset done", 64'(done), 64'(0));
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset result", result, 64'h0);
        rst = 1'b0;
        step();

        // Unsigned 100/7, then take returns to IDLE
        run_op("u100/7", 1'b0, 32'd100, 32'd7, 33, 64'h00000002_0000000E);
        take = 1'b1;
        step();
        take = 1'b0;
        chk("u100/7 idle done", 64'(done), 64'(0));
        chk("u100/7 idle busy", 64'(busy), 64'(0));

        // Signed -7/2 and 7/-2
        run_op("s-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 33, 64'hFFFFFFFF_FFFFFFFD);
        take = 1'b1; step(); take = 1'b0;
        run_op("s7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD);
        take = 1'b1; step(); take = 1'b0;

        // Divide by zero finishes after one cycle
        run_op("div0", 1'b0, 32'h00001234, 32'h0, 1, 64'h00001234_FFFFFFFF);
        take = 1'b1; step(); take = 1'b0;

        // Flush at cycle 10 of a CALC; result keeps last value
        start = 1'b1; sign = 1'b0; opa = 32'd50; opb = 32'd5;
        step();
        start = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush done@11", 64'(done), 64'(0));
        chk("flush busy@11", 64'(busy), 64'(0));
        chk("flush result kept", result, 64'h00001234_FFFFFFFF);
        step();
        chk("flush done@12", 64'(done), 64'(0));
        run_op("u9/3", 1'b0, 32'd9, 32'd3, 33, 64'h00000000_00000003);
        take = 1'b1; step(); take = 1'b0;

        // Signed overflow case, then hold in DONE with a stray start and no take
        run_op("ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000);
        start = 1'b1; sign = 1'b0; opa = 32'd77; opb = 32'd3;
        for (int h = 0; h < 5; h++) begin
            #1;
            chk($sformatf("hold busy %0d", h), 64'(busy), 64'(0));
            step();
            chk($sformatf("hold done %0d", h), 64'(done), 64'(1));
            chk($sformatf("hold result %0d", h), result, 64'h00000000_80000000);
        end
        start = 1'b0;

        // take together with start launches the next op
        take = 1'b1;
        run_op("u10/4", 1'b0, 32'd10, 32'd4, 33, 64'h00000002_00000002);
        take = 1'b1; step(); take = 1'b0;

        // Dividend smaller than divisor (early-out when enabled)
        run_op("u5/9", 1'b0, 32'd5, 32'd9, early_lat, 64'h00000005_00000000);
        take = 1'b1; step(); take = 1'b0;
        chk("final idle done", 64'(done), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
